// File: rtl/key_press_emulator.sv
// key_press_emulator
//   Command-driven generator of a raw, bouncy push-button waveform:
//   press bounce, stable hold, release bounce, then a forced released gap.
//   One command in flight at a time, accepted on cmd_valid & cmd_ready.
//   Optional build macro KEY_EMU_LFSR_BOUNCE_EN: pseudo-random bounce
//   segment widths from an 8-bit LFSR instead of fixed bounce_us widths.
module key_press_emulator #(
   parameter int   sclk_freq      = 50_000_000,
   parameter logic press_vol      = 1'b0,
   parameter int   bounce_edges   = 4,
   parameter int   bounce_us      = 200,
   parameter int   release_gap_ms = 30
) (
   input  logic        sclk,
   input  logic        nrst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_hold_ms,
   input  logic        abort,
   output logic        key_emu,
   output logic        busy,
   output logic        done
);

   localparam int             US_CYC   = sclk_freq / 1_000_000;
   localparam int             PRE_W    = (US_CYC > 1) ? $clog2(US_CYC) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(US_CYC - 1);
   localparam logic [4:0]     LAST_SEG = (bounce_edges == 0) ? 5'd0 : 5'(2 * bounce_edges - 1);
   localparam logic [15:0]    GAP_MS   = 16'(release_gap_ms);
   localparam logic           PRESSED  = press_vol;
   localparam logic           RELEASED = ~press_vol;
   localparam logic           NO_BOUNCE = (bounce_edges == 0);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_BOUNCE,
      HOLD,
      RELEASE_BOUNCE,
      GAP
   } state_t;

   state_t            state, state_nxt;
   logic [4:0]        seg_idx, seg_nxt;
   logic [15:0]       hold_ms;
   logic [PRE_W-1:0]  us_pre;
   logic [9:0]        us_cnt;
   logic [15:0]       ms_cnt;
   logic [15:0]       phase_target;
   logic              restart;
   logic              accept;
   logic              us_tick;
   logic              seg_end;
   logic              ms_tick;
   logic              phase_end;
   logic              key_nxt;
   logic              done_nxt;
   logic [7:0]        seg_w;

`ifdef KEY_EMU_LFSR_BOUNCE_EN
   logic [7:0] lfsr;
   logic [7:0] lfsr_step;
   logic       seg_start;

   // LFSR successor (x^8+x^6+x^5+x^4+1) and bounce segment start detect
   always_comb begin
      lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      seg_start = restart && ((state_nxt == PRESS_BOUNCE) || (state_nxt == RELEASE_BOUNCE));
   end

   // Advance the LFSR once per bounce segment and derive that segment's width
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         lfsr  <= 8'hA5;
         seg_w <= 8'(bounce_us);
      end else if (seg_start) begin
         lfsr  <= lfsr_step;
         seg_w <= 8'({24'd0, lfsr_step} % 32'(bounce_us)) + 8'd1;
      end
   end
`else
   assign seg_w = 8'(bounce_us);
`endif

   // Timer decode: us tick, bounce segment end, ms tick, HOLD/GAP phase end
   always_comb begin
      us_tick      = (us_pre == PRE_MAX);
      seg_end      = us_tick && ((us_cnt + 10'd1) == {2'b00, seg_w});
      ms_tick      = us_tick && (us_cnt == 10'd999);
      phase_target = (state == HOLD) ? hold_ms : GAP_MS;
      phase_end    = ms_tick && ((ms_cnt + 16'd1) == phase_target);
   end

   // Next-state, segment index and next registered output values
   always_comb begin
      state_nxt = state;
      seg_nxt   = seg_idx;
      restart   = 1'b0;
      accept    = 1'b0;
      done_nxt  = 1'b0;
      key_nxt   = RELEASED;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept    = 1'b1;
               restart   = 1'b1;
               seg_nxt   = 5'd0;
               state_nxt = NO_BOUNCE ? HOLD : PRESS_BOUNCE;
            end
         end
         PRESS_BOUNCE: begin
            if (abort) begin
               restart   = 1'b1;
               seg_nxt   = 5'd0;
               state_nxt = NO_BOUNCE ? GAP : RELEASE_BOUNCE;
            end else if (seg_end) begin
               restart = 1'b1;
               if (seg_idx == LAST_SEG) begin
                  seg_nxt   = 5'd0;
                  state_nxt = HOLD;
               end else begin
                  seg_nxt = seg_idx + 5'd1;
               end
            end
         end
         HOLD: begin
            if (abort || phase_end) begin
               restart   = 1'b1;
               seg_nxt   = 5'd0;
               state_nxt = NO_BOUNCE ? GAP : RELEASE_BOUNCE;
            end
         end
         RELEASE_BOUNCE: begin
            if (seg_end) begin
               restart = 1'b1;
               if (seg_idx == LAST_SEG) begin
                  seg_nxt   = 5'd0;
                  state_nxt = GAP;
               end else begin
                  seg_nxt = seg_idx + 5'd1;
               end
            end
         end
         GAP: begin
            if (phase_end) begin
               restart   = 1'b1;
               seg_nxt   = 5'd0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            restart   = 1'b1;
            seg_nxt   = 5'd0;
            state_nxt = IDLE;
         end
      endcase

      case (state_nxt)
         HOLD:           key_nxt = PRESSED;
         PRESS_BOUNCE:   key_nxt = seg_nxt[0] ? RELEASED : PRESSED;
         RELEASE_BOUNCE: key_nxt = seg_nxt[0] ? PRESSED : RELEASED;
         default:        key_nxt = RELEASED;
      endcase
   end

   // State, segment, hold latch and registered outputs
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         seg_idx   <= 5'd0;
         hold_ms   <= 16'd0;
         key_emu   <= RELEASED;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         seg_idx   <= seg_nxt;
         if (accept) begin
            hold_ms <= (cmd_hold_ms == 16'd0) ? 16'd1 : cmd_hold_ms;
         end
         key_emu   <= key_nxt;
         cmd_ready <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
      end
   end

   // Timing chain: us prescaler -> us counter -> ms counter, cleared on every change
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         us_pre <= '0;
         us_cnt <= 10'd0;
         ms_cnt <= 16'd0;
      end else if (restart || (state == IDLE)) begin
         us_pre <= '0;
         us_cnt <= 10'd0;
         ms_cnt <= 16'd0;
      end else if (us_tick) begin
         us_pre <= '0;
         if (ms_tick) begin
            us_cnt <= 10'd0;
            ms_cnt <= ms_cnt + 16'd1;
         end else begin
            us_cnt <= us_cnt + 10'd1;
         end
      end else begin
         us_pre <= us_pre + PRE_W'(1);
      end
   end

endmodule

// File: tb/tb_key_press_emulator.sv
// tb_key_press_emulator
//   Directed bench: 2 MHz clock (2 cycles/us), 2 bounce pairs of 10 us
//   (20 cycles each), 1 ms release gap (2000 cycles), pressed level 0.
module tb_key_press_emulator;

   logic        sclk = 1'b0;
   logic        nrst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_hold_ms = 16'd0;
   logic        abort = 1'b0;
   logic        key_emu;
   logic        busy;
   logic        done;

   int n_pass  = 0;
   int n_total = 0;

   key_press_emulator #(
      .sclk_freq      (2_000_000),
      .press_vol      (1'b0),
      .bounce_edges   (2),
      .bounce_us      (10),
      .release_gap_ms (1)
   ) dut (
      .sclk        (sclk),
      .nrst        (nrst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_hold_ms (cmd_hold_ms),
      .abort       (abort),
      .key_emu     (key_emu),
      .busy        (busy),
      .done        (done)
   );

   always #5 sclk = ~sclk;

   // Expected key level k cycles after the accept edge (pressed = 0)
   function automatic logic exp_key(input int k, input int hold_cyc);
      int j;
      if (k < 80) return ((k / 20) % 2 == 0) ? 1'b0 : 1'b1;
      if (k < 80 + hold_cyc) return 1'b0;
      if (k < 160 + hold_cyc) begin
         j = k - 80 - hold_cyc;
         return ((j / 20) % 2 == 0) ? 1'b1 : 1'b0;
      end
      return 1'b1;
   endfunction

   // Present a command for one accept edge; returns at the first sample after accept
   task automatic issue(input logic [15:0] h);
      cmd_hold_ms = h;
      cmd_valid   = 1'b1;
      @(negedge sclk);
      cmd_valid   = 1'b0;
   endtask

   // Observe one command; stops at the negedge of the done cycle (or bound)
   task automatic watch_cmd(input int hold_cyc, output int key_err, output int busy_err,
                            output int done_at);
      int total;
      total    = 160 + hold_cyc + 2000;
      key_err  = 0;
      busy_err = 0;
      done_at  = -1;
      for (int k = 0; k <= total + 200; k++) begin
         if (done === 1'b1) begin
            done_at = k;
            break;
         end
         if (k < total) begin
            if (key_emu !== exp_key(k, hold_cyc)) key_err++;
            if (busy !== 1'b1) busy_err++;
         end
         @(negedge sclk);
      end
   endtask

   task automatic test_reset;
      @(negedge sclk);
      @(negedge sclk);
      n_total++; if (key_emu !== 1'b1) $display("FAIL reset_key: got %b want 1", key_emu); else n_pass++;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      nrst = 1'b1;
      @(negedge sclk);
   endtask

   task automatic test_press;
      int ke, be, da;
      issue(16'd3);
      watch_cmd(6000, ke, be, da);
      n_total++; if (ke !== 0) $display("FAIL press_wave: %0d key errors want 0", ke); else n_pass++;
      n_total++; if (be !== 0) $display("FAIL press_busy: %0d busy errors want 0", be); else n_pass++;
      n_total++; if (da !== 8160) $display("FAIL press_done_at: got %0d want 8160", da); else n_pass++;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL press_ready_at_done: got %b want 1", cmd_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL press_busy_at_done: got %b want 0", busy); else n_pass++;
      @(negedge sclk);
      n_total++; if (done !== 1'b0) $display("FAIL press_done_width: got %b want 0", done); else n_pass++;
      n_total++; if (key_emu !== 1'b1) $display("FAIL press_idle_key: got %b want 1", key_emu); else n_pass++;
   endtask

   task automatic test_hold_zero;
      int ke, be, da;
      issue(16'd0);
      watch_cmd(2000, ke, be, da);
      n_total++; if (ke !== 0) $display("FAIL hold0_wave: %0d key errors want 0", ke); else n_pass++;
      n_total++; if (da !== 4160) $display("FAIL hold0_done_at: got %0d want 4160", da); else n_pass++;
      @(negedge sclk);
      issue(16'd1);
      watch_cmd(2000, ke, be, da);
      n_total++; if (ke !== 0) $display("FAIL hold1_wave: %0d key errors want 0", ke); else n_pass++;
      n_total++; if (da !== 4160) $display("FAIL hold1_done_at: got %0d want 4160", da); else n_pass++;
      @(negedge sclk);
   endtask

   task automatic test_valid_while_busy;
      int n_done, first;
      n_done = 0;
      first  = -1;
      issue(16'd1);
      for (int k = 0; k < 4500; k++) begin
         if (done === 1'b1) begin
            n_done++;
            if (first < 0) first = k;
         end
         if (k == 300) cmd_valid = 1'b1;
         if (k == 301) cmd_valid = 1'b0;
         @(negedge sclk);
      end
      n_total++; if (first !== 4160) $display("FAIL busy_valid_done_at: got %0d want 4160", first); else n_pass++;
      n_total++; if (n_done !== 1) $display("FAIL busy_valid_done_count: got %0d want 1", n_done); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL busy_valid_no_queue: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int ke, be, da;
      cmd_hold_ms = 16'd1;
      cmd_valid   = 1'b1;
      @(negedge sclk);
      watch_cmd(2000, ke, be, da);
      n_total++; if (da !== 4160) $display("FAIL b2b_first_done_at: got %0d want 4160", da); else n_pass++;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_idle_cycle: got %b want 1", cmd_ready); else n_pass++;
      @(negedge sclk);
      cmd_valid = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_second_accept_busy: got %b want 1", busy); else n_pass++;
      n_total++; if (key_emu !== 1'b0) $display("FAIL b2b_second_accept_key: got %b want 0", key_emu); else n_pass++;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_second_ready: got %b want 0", cmd_ready); else n_pass++;
      watch_cmd(2000, ke, be, da);
      n_total++; if (ke !== 0) $display("FAIL b2b_second_wave: %0d key errors want 0", ke); else n_pass++;
      n_total++; if (da !== 4160) $display("FAIL b2b_second_done_at: got %0d want 4160", da); else n_pass++;
      @(negedge sclk);
   endtask

   task automatic test_abort;
      int done_j;
      logic key20;
      done_j = -1;
      key20  = 1'bx;
      issue(16'd3);
      for (int k = 0; k < 180; k++) @(negedge sclk);
      n_total++; if (key_emu !== 1'b0) $display("FAIL abort_pre_hold_key: got %b want 0", key_emu); else n_pass++;
      abort = 1'b1;
      @(negedge sclk);
      abort = 1'b0;
      n_total++; if (key_emu !== 1'b1) $display("FAIL abort_release_key: got %b want 1", key_emu); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else n_pass++;
      for (int j = 0; j < 3000; j++) begin
         if (done === 1'b1) begin
            done_j = j;
            break;
         end
         if (j == 20) key20 = key_emu;
         if (j == 40 || j == 500) abort = 1'b1;
         if (j == 41 || j == 501) abort = 1'b0;
         @(negedge sclk);
      end
      abort = 1'b0;
      n_total++; if (key20 !== 1'b0) $display("FAIL abort_rb_seg1_key: got %b want 0", key20); else n_pass++;
      n_total++; if (done_j !== 2080) $display("FAIL abort_done_at: got %0d want 2080", done_j); else n_pass++;
      @(negedge sclk);
   endtask

   task automatic test_abort_idle_and_reset;
      int n_done, n_busy;
      n_done = 0;
      n_busy = 0;
      abort  = 1'b1;
      repeat (3) @(negedge sclk);
      n_total++; if (busy !== 1'b0) $display("FAIL abort_idle_busy: got %b want 0", busy); else n_pass++;
      cmd_hold_ms = 16'd3;
      cmd_valid   = 1'b1;
      @(negedge sclk);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL abort_accept_busy: got %b want 1", busy); else n_pass++;
      n_total++; if (key_emu !== 1'b0) $display("FAIL abort_accept_key: got %b want 0", key_emu); else n_pass++;
      for (int k = 0; k < 100; k++) @(negedge sclk);
      nrst = 1'b0;
      #1;
      n_total++; if (key_emu !== 1'b1) $display("FAIL midreset_key: got %b want 1", key_emu); else n_pass++;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", cmd_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL midreset_done: got %b want 0", done); else n_pass++;
      repeat (2) @(negedge sclk);
      nrst = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if (done === 1'b1) n_done++;
         if (busy !== 1'b0) n_busy++;
         @(negedge sclk);
      end
      n_total++; if (n_done !== 0) $display("FAIL midreset_no_done: got %0d want 0", n_done); else n_pass++;
      n_total++; if (n_busy !== 0) $display("FAIL midreset_stays_idle: got %0d want 0", n_busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_press();
      test_hold_zero();
      test_valid_while_busy();
      test_back_to_back();
      test_abort();
      test_abort_idle_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
